scene_fade: RTL and testbench

SCENE_FADE -- requirements
Module: scene_fade

---
 rtl/scene_fade.sv | 142 ++++++++++++++
 tb/tb_scene_fade.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/scene_fade.sv
// scene_fade -- frame-rate alpha fade between a source pixel stream and a
// fixed scene colour (RGB565).
//
// Ports:
//   iSysClk, iSysRst      clock and synchronous active-high reset
//   iSceneColor           fade target colour
//   iSceneFrameTiming     frames per alpha step, minus 1
//   iSceneFrameAddEn      fade toward scene colour (alpha up)
//   iSceneFrameSubEn      fade toward source pixel (alpha down)
//   iSceneFrameRst        clears alpha and frame counter
//   iFrameStart           one-cycle pulse per frame
//   iPixel, iPixelVd      source pixel stream
//   oPixel, oPixelVd      blended pixel stream, 2-cycle latency
//   oAlpha                current alpha, 0..pAlphaMax
//   oSceneAlphaMax/Min    registered alpha-at-limit flags
module scene_fade #(
    parameter int pColorDepth = 16,
    parameter int pAlphaMax   = 64
) (
    input  logic                   iSysClk,
    input  logic                   iSysRst,
    input  logic [pColorDepth-1:0] iSceneColor,
    input  logic [6:0]             iSceneFrameTiming,
    input  logic                   iSceneFrameAddEn,
    input  logic                   iSceneFrameSubEn,
    input  logic                   iSceneFrameRst,
    input  logic                   iFrameStart,
    input  logic [pColorDepth-1:0] iPixel,
    input  logic                   iPixelVd,
    output logic [pColorDepth-1:0] oPixel,
    output logic                   oPixelVd,
    output logic [6:0]             oAlpha,
    output logic                   oSceneAlphaMax,
    output logic                   oSceneAlphaMin
);

    localparam logic [6:0] cAlphaMax = 7'(pAlphaMax);
    localparam int         cShift    = $clog2(pAlphaMax);

    typedef enum logic [1:0] {
        MODE_HOLD,
        MODE_ADD,
        MODE_SUB
    } stepMode_t;

    stepMode_t  stepMode;
    logic [6:0] alpha;
    logic [6:0] frameCnt;
    logic [6:0] alphaNext;
    logic [6:0] frameCntNext;
    logic [6:0] alphaInv;

    // Stage 1 product registers; each channel keeps the source and scene
    // terms separate so the adder sits entirely in stage 2.
    logic        s1Vd;
    logic [11:0] s1PixR;
    logic [11:0] s1ScnR;
    logic [12:0] s1PixG;
    logic [12:0] s1ScnG;
    logic [11:0] s1PixB;
    logic [11:0] s1ScnB;

    // Both enables (or neither) hold the fade.
    always_comb begin
        stepMode = MODE_HOLD;
        if (iSceneFrameAddEn && !iSceneFrameSubEn) begin
            stepMode = MODE_ADD;
        end else if (iSceneFrameSubEn && !iSceneFrameAddEn) begin
            stepMode = MODE_SUB;
        end
    end

    // ">=" rather than "==" so a timing value lowered below the running
    // count still produces a step on the next frame instead of a long wrap.
    always_comb begin
        alphaNext    = alpha;
        frameCntNext = frameCnt;
        if (iSceneFrameRst) begin
            alphaNext    = '0;
            frameCntNext = '0;
        end else if (iFrameStart && (stepMode != MODE_HOLD)) begin
            if (frameCnt >= iSceneFrameTiming) begin
                frameCntNext = '0;
                if ((stepMode == MODE_ADD) && (alpha < cAlphaMax)) begin
                    alphaNext = alpha + 7'd1;
                end else if ((stepMode == MODE_SUB) && (alpha != '0)) begin
                    alphaNext = alpha - 7'd1;
                end
            end else begin
                frameCntNext = frameCnt + 7'd1;
            end
        end
    end

    always_ff @(posedge iSysClk) begin
        if (iSysRst) begin
            alpha          <= '0;
            frameCnt       <= '0;
            oSceneAlphaMax <= 1'b0;
            oSceneAlphaMin <= 1'b1;
        end else begin
            alpha          <= alphaNext;
            frameCnt       <= frameCntNext;
            oSceneAlphaMax <= (alpha == cAlphaMax);
            oSceneAlphaMin <= (alpha == '0);
        end
    end

    assign oAlpha   = alpha;
    assign alphaInv = cAlphaMax - alpha;

    // Stage 1: alpha and scene colour are sampled together with the pixel.
    always_ff @(posedge iSysClk) begin
        if (iSysRst) begin
            s1Vd <= 1'b0;
        end else begin
            s1Vd <= iPixelVd;
        end
        s1PixR <= 12'(iPixel[15:11])      * 12'(alphaInv);
        s1ScnR <= 12'(iSceneColor[15:11]) * 12'(alpha);
        s1PixG <= 13'(iPixel[10:5])       * 13'(alphaInv);
        s1ScnG <= 13'(iSceneColor[10:5])  * 13'(alpha);
        s1PixB <= 12'(iPixel[4:0])        * 12'(alphaInv);
        s1ScnB <= 12'(iSceneColor[4:0])   * 12'(alpha);
    end

    // Stage 2: sum and normalise; oPixel holds between valid pixels.
    always_ff @(posedge iSysClk) begin
        if (iSysRst) begin
            oPixelVd <= 1'b0;
            oPixel   <= '0;
        end else begin
            oPixelVd <= s1Vd;
            if (s1Vd) begin
                oPixel <= pColorDepth'({5'((s1PixR + s1ScnR) >> cShift),
                                        6'((s1PixG + s1ScnG) >> cShift),
                                        5'((s1PixB + s1ScnB) >> cShift)});
            end
        end
    end

endmodule

// File: tb/tb_scene_fade.sv
module tb_scene_fade;

    logic        iSysClk = 1'b0;
    logic        iSysRst;
    logic [15:0] iSceneColor;
    logic [6:0]  iSceneFrameTiming;
    logic        iSceneFrameAddEn;
    logic        iSceneFrameSubEn;
    logic        iSceneFrameRst;
    logic        iFrameStart;
    logic [15:0] iPixel;
    logic        iPixelVd;
    logic [15:0] oPixel;
    logic        oPixelVd;
    logic [6:0]  oAlpha;
    logic        oSceneAlphaMax;
    logic        oSceneAlphaMin;

    always #5 iSysClk = ~iSysClk;

    scene_fade #(.pColorDepth(16), .pAlphaMax(64)) dut (
        .iSysClk          (iSysClk),
        .iSysRst          (iSysRst),
        .iSceneColor      (iSceneColor),
        .iSceneFrameTiming(iSceneFrameTiming),
        .iSceneFrameAddEn (iSceneFrameAddEn),
        .iSceneFrameSubEn (iSceneFrameSubEn),
        .iSceneFrameRst   (iSceneFrameRst),
        .iFrameStart      (iFrameStart),
        .iPixel           (iPixel),
        .iPixelVd         (iPixelVd),
        .oPixel           (oPixel),
        .oPixelVd         (oPixelVd),
        .oAlpha           (oAlpha),
        .oSceneAlphaMax   (oSceneAlphaMax),
        .oSceneAlphaMin   (oSceneAlphaMin)
    );

    int nCmp  = 0;
    int nFail = 0;

    // Reference state: fade level/frame count as integers, and the pixel
    // pipeline as "final blended value in flight" plus the visible output.
    int mA, mC;
    int mS1Vd, mS1Val;
    int mOutVd, mOut;
    int mMax, mMin;

    function automatic int blend(int pix, int scn, int a);
        int r, g, b;
        r = (((pix >> 11) & 31) * (64 - a) + ((scn >> 11) & 31) * a) / 64;
        g = (((pix >> 5)  & 63) * (64 - a) + ((scn >> 5)  & 63) * a) / 64;
        b = ((pix         & 31) * (64 - a) + (scn         & 31) * a) / 64;
        return (r << 11) | (g << 5) | b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock: update the reference from the current inputs,
    // clock the DUT, then compare every output.
    task automatic step();
        if (iSysRst) begin
            mA = 0; mC = 0; mS1Vd = 0; mOutVd = 0; mOut = 0; mMax = 0; mMin = 1;
        end else begin
            if (mS1Vd != 0) mOut = mS1Val;
            mOutVd = mS1Vd;
            mS1Vd  = int'(iPixelVd);
            mS1Val = blend(int'(iPixel), int'(iSceneColor), mA);
            mMin   = (mA == 0)  ? 1 : 0;
            mMax   = (mA == 64) ? 1 : 0;
            if (iSceneFrameRst) begin
                mA = 0; mC = 0;
            end else if (iFrameStart && (iSceneFrameAddEn != iSceneFrameSubEn)) begin
                if (mC >= int'(iSceneFrameTiming)) begin
                    mC = 0;
                    if (iSceneFrameAddEn) mA = (mA < 64) ? mA + 1 : 64;
                    else                  mA = (mA > 0)  ? mA - 1 : 0;
                end else begin
                    mC++;
                end
            end
        end
        @(posedge iSysClk);
        #1;
        check("pixVd", 32'(oPixelVd), 32'(mOutVd));
        check("pixel", 32'(oPixel), 32'(mOut));
        check("alpha", 32'(oAlpha), 32'(mA));
        check("maxFlag", 32'(oSceneAlphaMax), 32'(mMax));
        check("minFlag", 32'(oSceneAlphaMin), 32'(mMin));
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            iFrameStart = 1'b1;
            step();
            iFrameStart = 1'b0;
            step();
        end
    endtask

    initial begin
        int a0;
        iSysRst = 1'b1; iSceneColor = '0; iSceneFrameTiming = '0;
        iSceneFrameAddEn = 1'b0; iSceneFrameSubEn = 1'b0; iSceneFrameRst = 1'b0;
        iFrameStart = 1'b0; iPixel = '0; iPixelVd = 1'b0;
        mA = 0; mC = 0; mS1Vd = 0; mS1Val = 0; mOutVd = 0; mOut = 0; mMax = 0; mMin = 1;
        #2;
        step(); step();
        iSysRst = 1'b0;
        check("rstAlpha", 32'(oAlpha), 32'd0);
        check("rstMin", 32'(oSceneAlphaMin), 32'd1);
        check("rstMax", 32'(oSceneAlphaMax), 32'd0);
        check("rstVd", 32'(oPixelVd), 32'd0);

        // Pass-through at alpha 0, then hold while invalid.
        iPixel = 16'h1234; iPixelVd = 1'b1; step();
        iPixelVd = 1'b0; iPixel = 16'hABCD; step();
        check("passPix", 32'(oPixel), 32'h1234);
        check("passVd", 32'(oPixelVd), 32'd1);
        step();
        check("holdPix", 32'(oPixel), 32'h1234);

        // Half blend toward black, then full scene colour.
        iSceneFrameTiming = 7'd0; iSceneFrameAddEn = 1'b1;
        frames(32);
        check("alpha32", 32'(oAlpha), 32'd32);
        iSceneColor = 16'h0000; iPixel = 16'hFFFF; iPixelVd = 1'b1; step();
        iPixelVd = 1'b0; step();
        check("blendHalf", 32'(oPixel), 32'h7BEF);
        frames(32);
        iSceneColor = 16'hF800; iPixel = 16'(($urandom)); iPixelVd = 1'b1; step();
        iPixelVd = 1'b0; step();
        check("blendFull", 32'(oPixel), 32'hF800);
        check("alpha64", 32'(oAlpha), 32'd64);

        // Frame timing 2: one step per three frames, saturating at 64.
        iSceneFrameRst = 1'b1; step(); iSceneFrameRst = 1'b0; step();
        iSceneFrameTiming = 7'd2;
        frames(3);
        check("timing3", 32'(oAlpha), 32'd1);
        frames(3);
        check("timing6", 32'(oAlpha), 32'd2);
        frames(185);
        iFrameStart = 1'b1; step();
        check("reach64", 32'(oAlpha), 32'd64);
        check("maxLag", 32'(oSceneAlphaMax), 32'd0);
        iFrameStart = 1'b0; step();
        check("maxSet", 32'(oSceneAlphaMax), 32'd1);
        frames(6);
        check("sat64", 32'(oAlpha), 32'd64);

        // Fade out to zero, then hold with both enables.
        iSceneFrameTiming = 7'd0; iSceneFrameAddEn = 1'b0; iSceneFrameSubEn = 1'b1;
        frames(64);
        check("fadeOut", 32'(oAlpha), 32'd0);
        check("minSet", 32'(oSceneAlphaMin), 32'd1);
        frames(2);
        check("sat0", 32'(oAlpha), 32'd0);
        iSceneFrameAddEn = 1'b1; iSceneFrameSubEn = 1'b0;
        frames(20);
        iSceneFrameSubEn = 1'b1;
        frames(10);
        check("holdBoth", 32'(oAlpha), 32'd20);

        // Timing lowered below the running count steps on the next frame.
        iSceneFrameSubEn = 1'b0; iSceneFrameTiming = 7'd5;
        frames(4);
        a0 = int'(oAlpha);
        iSceneFrameTiming = 7'd1;
        frames(1);
        check("lowerTiming", 32'(oAlpha), 32'(a0 + 1));

        // Fade reset coincident with a frame start at A=40, C=1.
        iSceneFrameRst = 1'b1; step(); iSceneFrameRst = 1'b0;
        iSceneFrameTiming = 7'd0;
        frames(40);
        iSceneFrameTiming = 7'd3;
        frames(1);
        check("a40", 32'(oAlpha), 32'd40);
        iFrameStart = 1'b1; iSceneFrameRst = 1'b1; step();
        check("frameRst", 32'(oAlpha), 32'd0);
        iFrameStart = 1'b0; iSceneFrameRst = 1'b0; step();
        frames(3);
        check("cntCleared", 32'(oAlpha), 32'd0);
        frames(1);
        check("cntStep", 32'(oAlpha), 32'd1);

        // Randomised stream with interleaved frame pulses and mode changes.
        for (int i = 0; i < 600; i++) begin
            iPixel            = 16'($urandom);
            iPixelVd          = ($urandom_range(0, 3) != 0);
            iSceneColor       = (($urandom_range(0, 7) == 0)) ? 16'($urandom) : iSceneColor;
            iFrameStart       = ($urandom_range(0, 2) == 0);
            iSceneFrameAddEn  = ($urandom_range(0, 3) != 0);
            iSceneFrameSubEn  = ($urandom_range(0, 3) == 0);
            iSceneFrameTiming = 7'($urandom_range(0, 3));
            iSceneFrameRst    = ($urandom_range(0, 60) == 0);
            step();
        end
        iFrameStart = 1'b0; iSceneFrameRst = 1'b0;

        // System reset with pixels in flight.
        iSceneFrameAddEn = 1'b1; iSceneFrameSubEn = 1'b0; iSceneFrameTiming = 7'd0;
        frames(10);
        for (int i = 0; i < 4; i++) begin
            iPixel = 16'($urandom); iPixelVd = 1'b1; step();
        end
        iSysRst = 1'b1; iPixelVd = 1'b0; step();
        check("midRstVd", 32'(oPixelVd), 32'd0);
        check("midRstPix", 32'(oPixel), 32'd0);
        check("midRstAlpha", 32'(oAlpha), 32'd0);
        check("midRstMin", 32'(oSceneAlphaMin), 32'd1);
        iSysRst = 1'b0; step();
        check("noStaleVd", 32'(oPixelVd), 32'd0);
        step();
        check("noStaleVd2", 32'(oPixelVd), 32'd0);

        // First frames after reset count from zero.
        iSceneFrameTiming = 7'd1;
        frames(1);
        check("postRst1", 32'(oAlpha), 32'd0);
        frames(1);
        check("postRst2", 32'(oAlpha), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
